// File: rtl/acia_pkg.sv
// Shared receiver types: FSM states, parity-mode and word-length encodings, word-length decode.
// When ACIA_RX_BREAK_EN is defined, this adds the BRK state and a break flag to each buffered entry.
package acia_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_STOP2
`ifdef ACIA_RX_BREAK_EN
    , S_BRK
`endif
  } rx_state_e;

  typedef enum logic [1:0] {
    PMC_ODD   = 2'b00,
    PMC_EVEN  = 2'b01,
    PMC_MARK  = 2'b10,
    PMC_SPACE = 2'b11
  } pmc_e;

  typedef enum logic [1:0] {
    WL_8 = 2'b00,
    WL_7 = 2'b01,
    WL_6 = 2'b10,
    WL_5 = 2'b11
  } wl_e;

  // Entry layout, MSB first: [brk,] data[7:0], frame, parity
`ifdef ACIA_RX_BREAK_EN
  localparam int ENTRY_W = 11;
`else
  localparam int ENTRY_W = 10;
`endif

  function automatic logic [3:0] wl_bits(input logic [1:0] wl);
    logic [3:0] n;
    case (wl)
      WL_8:    n = 4'd8;
      WL_7:    n = 4'd7;
      WL_6:    n = 4'd6;
      default: n = 4'd5;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/acia_sync_fifo.sv
// Single-clock FIFO; the head is always visible (zero when empty). A pop and a push in the same
// cycle are both honoured even when the FIFO is full. A push while full with no pop is dropped.
module acia_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_dat_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/acia_rx_fifo.sv
// ACIA receiver: oversampled async RX deserialiser feeding a small word buffer with error flags.
// When ACIA_RX_BREAK_EN is defined, this adds break detection (BRK state, BREAK output).
module acia_rx_fifo
  import acia_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              PHI2,
  input  logic                              RESET,
  input  logic                              BCLK_EN,
  input  logic                              RX,
  input  logic [1:0]                        R_WL,
  input  logic                              R_PME,
  input  logic [1:0]                        R_PMC,
  input  logic                              R_SBN,
  input  logic                              RXTAKEN,
  output logic [7:0]                        RXDATA,
  output logic                              RXFULL,
  output logic                              FRAME,
  output logic                              PARITY,
  output logic                              OVERFLOW,
  output logic                              BREAK,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   RXCOUNT
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_T = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_T = TW'(OVERSAMPLE - 1);

  logic               rx_s1_q, rx_s2_q;
  rx_state_e          state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         data_q, data_d;
  logic               perr_q, perr_d;
  logic               ovf_q, ovf_d;
  logic               sample, push, frame_bit;
  logic [2:0]         last_idx;
  logic [ENTRY_W-1:0] push_dat, head_dat;
  logic               fifo_full, fifo_empty, pop_eff;
`ifdef ACIA_RX_BREAK_EN
  logic               pbit_q, pbit_d;
  logic               brk_q, brk_d;
  logic               brk_bit;
`endif

  assign last_idx = 3'(wl_bits(R_WL) - 4'd1);
  assign pop_eff  = RXTAKEN && !fifo_empty;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    data_d    = data_q;
    perr_d    = perr_q;
    sample    = 1'b0;
    push      = 1'b0;
    frame_bit = 1'b0;
`ifdef ACIA_RX_BREAK_EN
    pbit_d    = pbit_q;
    brk_bit   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          state_d = S_START;
          tick_d  = '0;
          bit_d   = '0;
          data_d  = '0;
          perr_d  = 1'b0;
`ifdef ACIA_RX_BREAK_EN
          pbit_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (BCLK_EN) begin
          if (tick_q == HALF_T) begin
            tick_d  = '0;
            state_d = rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        if (BCLK_EN) begin
          if (tick_q == FULL_T) begin
            tick_d = '0;
            sample = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
    endcase

    if (sample) begin
      case (state_q)
        S_DATA: begin
          data_d[bit_q] = rx_s2_q;
          // >= keeps the FSM moving if R_WL shrinks mid-frame
          if (bit_q >= last_idx) state_d = R_PME ? S_PARITY : S_STOP;
          else                   bit_d   = bit_q + 3'd1;
        end
        S_PARITY: begin
          case (R_PMC)
            PMC_ODD:  perr_d = ~(^data_q ^ rx_s2_q);
            PMC_EVEN: perr_d = ^data_q ^ rx_s2_q;
            PMC_MARK: perr_d = ~rx_s2_q;
            default:  perr_d = rx_s2_q;
          endcase
`ifdef ACIA_RX_BREAK_EN
          pbit_d = rx_s2_q;
`endif
          state_d = S_STOP;
        end
        S_STOP: begin
          push      = 1'b1;
          frame_bit = ~rx_s2_q;
          state_d   = (R_SBN && !R_PME) ? S_STOP2 : S_IDLE;
`ifdef ACIA_RX_BREAK_EN
          brk_bit = !rx_s2_q && (data_q == 8'h00) && !pbit_q;
          if (brk_bit) state_d = S_BRK;
`endif
        end
`ifdef ACIA_RX_BREAK_EN
        S_BRK: begin
          if (rx_s2_q) state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !pop_eff) ovf_d = 1'b1;
    else if (pop_eff)                  ovf_d = 1'b0;
  end

`ifdef ACIA_RX_BREAK_EN
  assign push_dat = {brk_bit, data_q, frame_bit, perr_q};

  always_comb begin
    brk_d = brk_q;
    if (pop_eff && head_dat[10])                            brk_d = 1'b0;
    if (push && brk_bit && (!fifo_full || pop_eff))         brk_d = 1'b1;
  end

  always_ff @(posedge PHI2) begin
    if (!RESET) begin
      pbit_q <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      pbit_q <= pbit_d;
      brk_q  <= brk_d;
    end
  end

  assign BREAK = brk_q;
`else
  assign push_dat = {data_q, frame_bit, perr_q};
  assign BREAK    = 1'b0;
`endif

  always_ff @(posedge PHI2) begin
    if (!RESET) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
    end
  end

  acia_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (PHI2),
    .rst_n_i    (RESET),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (RXTAKEN),
    .head_dat_o (head_dat),
    .count_o    (RXCOUNT),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign RXDATA   = head_dat[9:2];
  assign FRAME    = head_dat[1];
  assign PARITY   = head_dat[0];
  assign RXFULL   = !fifo_empty;
  assign OVERFLOW = ovf_q;

endmodule
